// File: rtl/cpu_player_if.sv
// Key-press bus between the computer opponent and the playfield:
// game-side controls (enable, speed) in, press pulse and LFSR debug value out.
interface cpu_player_if #(
  parameter int unsigned LFSR_W  = 10,
  parameter int unsigned SPEED_W = 9
);
  logic               enable;
  logic [SPEED_W-1:0] speed;
  logic               press;
  logic [LFSR_W-1:0]  lfsr;

  modport master (output enable, output speed, input press, input lfsr);
  modport slave  (input enable, input speed, output press, output lfsr);
endinterface

// File: rtl/cpu_player.sv
// Computer opponent for tug-of-war: emits one-cycle press pulses whenever the
// difficulty value beats a free-running 10-bit LFSR, with a post-press cooldown.
module cpu_player #(
  parameter int unsigned LFSR_W   = 10,
  parameter int unsigned SPEED_W  = 9,
  parameter int unsigned COOLDOWN = 2
) (
  input  logic         clk,
  input  logic         reset,
  cpu_player_if.slave  bus
);

  localparam int unsigned CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam bit HAS_COOL = (COOLDOWN > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               press_q;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [LFSR_W-1:0]  lfsr_next_c;
  logic               hit_c;

  // Maximal-length XNOR LFSR (taps 9 and 6); all-ones is unreachable from zero.
  assign lfsr_next_c = {lfsr_q[LFSR_W-2:0], ~(lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-4])};

  // Compare against the pre-advance LFSR value; speed zero-extended.
  assign hit_c = bus.enable && (LFSR_W'(bus.speed) > lfsr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      press_q <= 1'b0;
      lfsr_q  <= '0;
    end else begin
      lfsr_q  <= lfsr_next_c;
      press_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hit_c) begin
            state   <= PRESS;
            press_q <= 1'b1;
          end
        end
        PRESS: begin
          // A press in flight always completes; a dropped enable skips the cooldown.
          if (bus.enable && HAS_COOL) begin
            state <= COOL;
            cnt   <= CNT_INIT;
          end else begin
            state <= IDLE;
          end
        end
        COOL: begin
          if (!bus.enable || (cnt == '0)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.press = press_q;
  assign bus.lfsr  = lfsr_q;

endmodule

// File: tb/tb_cpu_player.sv
// Scoreboard bench for cpu_player: three instances (cooldown 2 / 9-bit speed,
// cooldown 2 / 10-bit speed, cooldown 0 / 10-bit speed) against a timing-rule model.
module tb_cpu_player;

  localparam int NI = 3;
  localparam int CD [NI] = '{2, 2, 0};
  localparam int SMAX [NI] = '{511, 1023, 1023};
  localparam int SEQ [8] = '{1, 3, 7, 15, 31, 63, 127, 254};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bit en [NI];
  int spd [NI];

  cpu_player_if #(.LFSR_W(10), .SPEED_W(9))  bus0 ();
  cpu_player_if #(.LFSR_W(10), .SPEED_W(10)) bus1 ();
  cpu_player_if #(.LFSR_W(10), .SPEED_W(10)) bus2 ();

  assign bus0.enable = en[0];
  assign bus1.enable = en[1];
  assign bus2.enable = en[2];
  assign bus0.speed  = 9'(spd[0]);
  assign bus1.speed  = 10'(spd[1]);
  assign bus2.speed  = 10'(spd[2]);

  cpu_player #(.LFSR_W(10), .SPEED_W(9),  .COOLDOWN(2)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  cpu_player #(.LFSR_W(10), .SPEED_W(10), .COOLDOWN(2)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  cpu_player #(.LFSR_W(10), .SPEED_W(10), .COOLDOWN(0)) u2 (.clk(clk), .reset(reset), .bus(bus2));

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    bit [NI-1:0] press;
    int          lfsr;
  } exp_t;

  exp_t sb [$];

  // Reference model: a press may start at edge k only if k is at least
  // cooldown+2 edges past the previous press start, or at least 2 edges past it
  // with enable having been low at some edge since.
  int m_lfsr = 0;
  int m_k = 0;
  int last_p [NI] = '{-1000, -1000, -1000};
  bit drop [NI] = '{0, 0, 0};

  always @(posedge clk or posedge reset) begin
    exp_t e;
    bit idle;
    bit hit;
    if (reset) begin
      m_lfsr = 0;
      m_k = 0;
      for (int i = 0; i < NI; i++) begin
        last_p[i] = -1000;
        drop[i] = 1'b0;
      end
      sb.delete();
    end else begin
      for (int i = 0; i < NI; i++) begin
        idle = (m_k >= last_p[i] + CD[i] + 2) || ((m_k >= last_p[i] + 2) && drop[i]);
        hit = en[i] && (spd[i] > m_lfsr);
        e.press[i] = idle && hit;
        if (e.press[i]) begin
          last_p[i] = m_k;
          drop[i] = 1'b0;
        end else if (!en[i]) begin
          drop[i] = 1'b1;
        end
      end
      m_lfsr = ((m_lfsr * 2) % 1024) + ((((m_lfsr / 512) % 2) == ((m_lfsr / 64) % 2)) ? 1 : 0);
      e.lfsr = m_lfsr;
      m_k++;
      sb.push_back(e);
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the model's expectation.
  int since_rst = 0;
  bit [NI-1:0] prev = '0;
  bit [NI-1:0] act;
  int press_cnt [NI] = '{0, 0, 0};

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      since_rst = 0;
      prev = '0;
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {bus2.press, bus1.press, bus0.press};
      for (int i = 0; i < NI; i++) begin
        check($sformatf("press[u%0d]", i), int'(act[i]), int'(e.press[i]));
        if (act[i]) check($sformatf("back_to_back[u%0d]", i), int'(prev[i]), 0);
        if (act[i]) press_cnt[i]++;
      end
      check("lfsr[u0]", int'(bus0.lfsr), e.lfsr);
      check("lfsr[u1]", int'(bus1.lfsr), e.lfsr);
      check("lfsr[u2]", int'(bus2.lfsr), e.lfsr);
      if (since_rst < 8) check("lfsr_seq", int'(bus0.lfsr), SEQ[since_rst]);
      since_rst++;
      prev = act;
    end
  end

  task automatic wait_press1(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (bus1.press) ok = 1'b1;
    end
    if (!ok) check("wait_press_timeout", 0, 1);
  endtask

  task automatic randomize_inputs(input bit keep_u0);
    for (int i = 0; i < NI; i++) begin
      if (keep_u0 && i == 0) continue;
      if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
      if ($urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 3) == 0) spd[i] = SMAX[i];
        else spd[i] = int'($urandom_range(0, SMAX[i]));
      end
    end
  endtask

  initial begin
    bit ok;
    en = '{1, 1, 1};
    spd = '{0, 1023, 1023};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_press[u0]", int'(bus0.press), 0);
    check("rst_press[u1]", int'(bus1.press), 0);
    check("rst_press[u2]", int'(bus2.press), 0);
    check("rst_lfsr[u0]", int'(bus0.lfsr), 0);
    check("rst_lfsr[u1]", int'(bus1.lfsr), 0);
    check("rst_lfsr[u2]", int'(bus2.lfsr), 0);

    // speed 0 on u0, max speed on u1/u2
    reset = 1'b0;
    repeat (2000) @(negedge clk);
    check("speed0_presses[u0]", press_cnt[0], 0);
    check("maxspeed_presses[u1]", press_cnt[1], 500);
    check("maxspeed_presses[u2]", press_cnt[2], 1000);

    // Async reset in the middle of a press cycle
    wait_press1(ok);
    #2 reset = 1'b1;
    #1;
    check("midpress_rst_press[u1]", int'(bus1.press), 0);
    check("midpress_rst_lfsr[u1]", int'(bus1.lfsr), 0);
    repeat (2) @(negedge clk);

    // speed 4 with enable already high at release: hit on lfsr=0
    spd[0] = 4;
    en = '{1, 1, 1};
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_press[u0]", int'(bus0.press), 1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      randomize_inputs(1'b1);
    end

    // Enable dropped during PRESS: pulse stays single, no press while low
    en = '{1, 1, 1};
    spd[1] = 1023;
    @(negedge clk);
    wait_press1(ok);
    @(negedge clk);
    en[1] = 1'b0;
    @(posedge clk);
    #1;
    check("drop_in_press[u1]", int'(bus1.press), 0);
    repeat (10) @(negedge clk);
    en[1] = 1'b1;

    // Enable dropped during COOL: cooldown discarded, press one edge earlier
    wait_press1(ok);
    @(negedge clk);
    @(negedge clk);
    en[1] = 1'b0;
    @(negedge clk);
    en[1] = 1'b1;
    @(posedge clk);
    #1;
    check("drop_in_cool_repress[u1]", int'(bus1.press), 1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      randomize_inputs(1'b0);
      if ($urandom_range(0, 63) == 0) spd[0] = int'($urandom_range(0, SMAX[0]));
    end
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
